// File: rtl/binary16_accumulator.sv
// Reduces a valid/ready packet of binary16 values to one sum by feeding pairs from an operand
// pool into an external pipelined adder and recycling its results until one value remains.
module binary16_accumulator #(
  parameter int unsigned POOL_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_valid,
  input  logic [15:0]      add_result,
  input  logic             add_result_valid,
  output logic [15:0]      sum_out,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             err_overflow
);

  localparam int unsigned CW    = $clog2(POOL_DEPTH + 1);
  localparam logic [CW:0] Depth = (CW + 1)'(POOL_DEPTH);

  logic [15:0]      pool_q [POOL_DEPTH];
  logic [15:0]      pool_d [POOL_DEPTH];
  logic [15:0]      ext    [POOL_DEPTH + 2];
  logic [CW-1:0]    cnt_q, cnt_d, fly_q, fly_d, pops, n;
  logic [CW:0]      tokens;
  logic             last_seen_q, sum_valid_q, add_valid_q, err_q;
  logic [15:0]      add_a_q, add_b_q, sum_q;
  logic [CNT_W-1:0] elem_q, sum_count_q;
  logic             issue, done, ret_ok, accept, ovf;

  assign tokens   = {1'b0, cnt_q} + {1'b0, fly_q};
  // Gated by rst so every output reads 0 while reset is held.
  assign in_ready = !rst && !last_seen_q && !sum_valid_q && (tokens < Depth);
  assign accept   = in_valid && in_ready;
  assign issue    = cnt_q >= CW'(2);
  assign done     = last_seen_q && (cnt_q == CW'(1)) && (fly_q == '0) && !sum_valid_q;
  assign ret_ok   = add_result_valid && (fly_q != '0);

  always_comb begin
    for (int i = 0; i < POOL_DEPTH; i++) ext[i] = pool_q[i];
    ext[POOL_DEPTH]     = '0;
    ext[POOL_DEPTH + 1] = '0;
    pops = issue ? CW'(2) : (done ? CW'(1) : '0);
    for (int i = 0; i < POOL_DEPTH; i++) begin
      if (issue)     pool_d[i] = ext[i + 2];
      else if (done) pool_d[i] = ext[i + 1];
      else           pool_d[i] = pool_q[i];
    end
    n   = cnt_q - pops;
    ovf = 1'b0;
    // Result is appended before the input element.
    if (ret_ok) begin
      if ({1'b0, n} < Depth) begin
        for (int i = 0; i < POOL_DEPTH; i++) if (CW'(i) == n) pool_d[i] = add_result;
        n = n + CW'(1);
      end else begin
        ovf = 1'b1;
      end
    end
    if (accept) begin
      if ({1'b0, n} < Depth) begin
        for (int i = 0; i < POOL_DEPTH; i++) if (CW'(i) == n) pool_d[i] = in_data;
        n = n + CW'(1);
      end else begin
        ovf = 1'b1;
      end
    end
    cnt_d = n;
    fly_d = fly_q;
    if (issue && !ret_ok)      fly_d = fly_q + CW'(1);
    else if (!issue && ret_ok) fly_d = fly_q - CW'(1);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < POOL_DEPTH; i++) pool_q[i] <= '0;
      cnt_q       <= '0;
      fly_q       <= '0;
      last_seen_q <= 1'b0;
      elem_q      <= '0;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      sum_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < POOL_DEPTH; i++) pool_q[i] <= pool_d[i];
      cnt_q       <= cnt_d;
      fly_q       <= fly_d;
      add_valid_q <= issue;
      if (issue) begin
        add_a_q <= pool_q[0];
        add_b_q <= pool_q[1];
      end
      if (ovf || (add_result_valid && (fly_q == '0))) err_q <= 1'b1;
      if (sum_valid_q && sum_ready) begin
        sum_valid_q <= 1'b0;
        last_seen_q <= 1'b0;
        elem_q      <= '0;
      end else begin
        if (done) begin
          sum_valid_q <= 1'b1;
          sum_q       <= pool_q[0];
          sum_count_q <= elem_q;
        end
        if (accept) begin
          if (elem_q != '1) elem_q <= elem_q + CNT_W'(1);
          if (in_last)      last_seen_q <= 1'b1;
        end
      end
    end
  end

  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_valid    = add_valid_q;
  assign sum_out      = sum_q;
  assign sum_count    = sum_count_q;
  assign sum_valid    = sum_valid_q;
  assign err_overflow = err_q;

endmodule

// File: doc/binary16_accumulator.md
Name: binary16_accumulator

Overview:
- Reduces a packet of binary16 values to a single binary16 sum.
- Sits directly upstream of the pipelined binary16 adder: it issues operand pairs to the adder and takes the adder's results back into its operand pool, until one value remains.
- Packets arrive on a valid/ready stream with a last flag. The sum leaves on a valid/ready output.

Parameters:
- POOL_DEPTH, 8, number of operand slots; also the cap on values held in the pool plus pairs in flight in the adder (≥2).
- CNT_W, 16, width of the element counter reported with each sum.

Ports:
- clk_in  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  16  binary16 element.
- in_valid  input  1  element present.
- in_last  input  1  final element of the packet; qualified by in_valid.
- in_ready  output  1  element accepted when in_valid && in_ready.
- add_a  output  16  adder operand a.
- add_b  output  16  adder operand b.
- add_valid  output  1  registered issue strobe to the adder's data_valid_in.
- add_result  input  16  adder result.
- add_result_valid  input  1  adder data_valid_out.
- sum_out  output  16  packet sum.
- sum_count  output  CNT_W  elements in the packet (saturating).
- sum_valid  output  1  sum available.
- sum_ready  input  1  consumer accepts the sum.
- err_overflow  output  1  sticky: a result returned with zero pairs in flight, or a pool overflow.

Behaviour:
- Reset: every output is 0. Pool count = 0, in-flight = 0, last_seen = 0, element count = 0. All registers clear asynchronously.
- Pool: an array of POOL_DEPTH 16-bit slots, compacted toward slot 0, plus a count.
  - Each cycle: up to two pops from slots 0 and 1, then up to two pushes appended in this order: adder result first, then input element.
- Tokens: tokens = pool count + in-flight.
- in_ready = !last_seen && (tokens < POOL_DEPTH); combinational from registered state.
  - An accepted element pushes into the pool and increments the element count.
  - If in_last, last_seen is set.
- Issue: when pool count ≥ 2 at the start of the cycle, slots 0 and 1 are popped.
  - On the next edge, add_a = slot0, add_b = slot1, add_valid = 1, and in-flight increments.
  - Otherwise add_valid = 0. At most one issue per cycle; add_valid is a single-cycle pulse per pair.
- Return: add_result_valid pushes add_result into the pool and decrements in-flight.
  - Issue and return in the same cycle leave in-flight unchanged.
- Error: add_result_valid with in-flight == 0 sets err_overflow; the result is dropped.
  - A push that would exceed POOL_DEPTH also sets err_overflow and is dropped.
  - err_overflow clears only on rst.
- Summation order is pool order, not input order. Results are bit-exact only for exactly representable partial sums.
- Done: when last_seen && pool count == 1 && in-flight == 0 && !sum_valid:
  - on the next edge sum_valid = 1, sum_out = slot0, sum_count = element count;
  - slot0 is popped.
- Hold: sum_out, sum_count and sum_valid hold until sum_valid && sum_ready.
  - On that edge sum_valid drops, and last_seen and element count clear. in_ready can rise in the following cycle.
- Single-element packet: the element becomes the sum without any issue. sum_valid rises 2 edges after acceptance.
- No new packet elements are accepted while last_seen or sum_valid is set. Packets never overlap.
- Element count saturates at all ones.
- Inputs: in_last without in_valid is ignored. The adder is assumed valid-in to valid-out with fixed latency and no stall; this block never throttles it.
- Reset mid-packet: everything clears immediately.
  - Adder results still in flight after reset deassertion set err_overflow, unless the adder is reset together with this block (required in integration).

Test Plan:
- Packet 0x3C00, 0x4000, 0x4200, 0x4400 (1, 2, 3, 4), one element per cycle, sum_ready = 1, behavioural adder with latency 6 → exactly 3 add_valid pulses; sum_out = 0x4900 (10.0), sum_count = 4, err_overflow = 0.
- Single element 0x4500 with in_last → no add_valid; sum_valid rises 2 edges after acceptance; sum_out = 0x4500, sum_count = 1.
- 20 elements of 0x3C00 back-to-back, POOL_DEPTH = 8 → in_ready deasserts whenever tokens = 8, never an overflow; sum_out = 0x4D00 (20.0), sum_count = 20, exactly 19 issues.
- Hold: sum_ready held 0 for 10 cycles after sum_valid → sum_out and sum_valid stable and in_ready = 0; sum_ready = 1 → sum_valid drops next edge and the next packet is accepted.
- Inject add_result_valid while idle → err_overflow = 1 and stays set; the next packet 0x4000, 0x4000 still sums to 0x4400.
- Assert rst asynchronously mid-packet, between clock edges → all outputs 0 immediately; a fresh packet 0x3C00, 0x3C00 → 0x4000, with the adder reset together with this block.
